// File: rtl/hash_func_pkg.sv
// Shared defaults and FSM state type for the cuckoo-hash index generator.
package hash_func_pkg;

  localparam int DEF_KEY_W   = 32;
  localparam int DEF_HASH_W  = 32;
  localparam int DEF_T1_SIZE = 11;
  localparam int DEF_T2_SIZE = 22;

  typedef enum logic [1:0] {
    IDLE,
    DIV1,
    DIV2,
    DONE
  } hash_state_e;

  // One extra bit so the shifted partial remainder never overflows before the compare.
  function automatic int rem_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/hash_func_seq_divider.sv
// Generic restoring shift-subtract divider: one quotient bit per cycle, DATA_W cycles.
// The first iteration happens on the start edge; done stays high until the next start.
module seq_divider #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DIV_W-1:0]  remainder
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  logic [CNT_W-1:0]  count_q;
  logic              loaded_q;
  logic [DIV_W-1:0]  rem_q, dsr_q;
  logic [DATA_W-1:0] quo_q;
  logic [DIV_W-1:0]  src_rem, src_dsr, trial, rem_d;
  logic [DATA_W-1:0] src_quo, quo_d;

  // The divisor is captured at start so the caller may change it mid-run.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dsr = start ? divisor : dsr_q;
    trial   = {src_rem[DIV_W-2:0], src_quo[DATA_W-1]};
    if (trial >= src_dsr) begin
      rem_d = trial - src_dsr;
      quo_d = {src_quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_d = trial;
      quo_d = {src_quo[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      loaded_q <= 1'b0;
      rem_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
    end else if (start) begin
      count_q  <= CNT_W'(1);
      loaded_q <= 1'b1;
      rem_q    <= rem_d;
      dsr_q    <= divisor;
      quo_q    <= quo_d;
    end else if (loaded_q && count_q != LAST) begin
      count_q  <= count_q + CNT_W'(1);
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  assign done      = loaded_q && (count_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hash_func.sv
// Cuckoo-hash index generator: hash1 = key % T1_SIZE, hash2 = (key / T1_SIZE) % T2_SIZE,
// computed by one shared sequential divider run twice.
module hash_func
  import hash_func_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int HASH_W  = DEF_HASH_W,
  parameter int T1_SIZE = DEF_T1_SIZE,
  parameter int T2_SIZE = DEF_T2_SIZE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [KEY_W-1:0]  key,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [HASH_W-1:0] hash1,
  output logic [HASH_W-1:0] hash2,
  output logic              out_valid,
  output hash_state_e       state_dbg
);

  // Handshake: a key is taken on any rising edge with in_valid & in_ready; in_ready is
  // high only in IDLE, in_valid while busy is ignored, out_valid is a one-cycle pulse.
  localparam int REM_W = rem_width(T1_SIZE, T2_SIZE);

  hash_state_e       state_q, state_d;
  logic              div_start, div_done;
  logic [KEY_W-1:0]  div_dividend, div_quotient;
  logic [REM_W-1:0]  div_divisor, div_remainder, r1_q;

  assign in_ready  = (state_q == IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = key;
    div_divisor  = REM_W'(T1_SIZE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = DIV1;
          div_start = 1'b1;
        end
      end
      DIV1: begin
        // Second pass divides the first quotient by the table-2 size.
        div_dividend = div_quotient;
        div_divisor  = REM_W'(T2_SIZE);
        if (div_done) begin
          state_d   = DIV2;
          div_start = 1'b1;
        end
      end
      DIV2: begin
        div_divisor = REM_W'(T2_SIZE);
        if (div_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r1_q      <= '0;
      hash1     <= '0;
      hash2     <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_q == DONE);
      if (state_q == DIV1 && div_done) r1_q <= div_remainder;
      if (state_q == DONE) begin
        hash1 <= HASH_W'(r1_q);
        hash2 <= HASH_W'(div_remainder);
      end
    end
  end

  seq_divider #(
    .DATA_W (KEY_W),
    .DIV_W  (REM_W)
  ) u_div (
    .clk       (clock),
    .rst_n     (reset_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

endmodule

// File: tb/tb_hash_func.sv
// Bench for hash_func: directed corner keys plus random keys against a % and / model,
// with per-result latency, pulse-width and output-hold checks.
module tb_hash_func;
  import hash_func_pkg::*;

  localparam int LAT = 65;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] key;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] hash1, hash2;
  logic        out_valid;
  hash_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [63:0] exp_q[$];
  int          acc_q[$];
  logic [63:0] last_res = '0;
  logic        prev_ov  = 1'b0;

  hash_func dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hash1     (hash1),
    .hash2     (hash2),
    .out_valid (out_valid),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] k);
    logic [31:0] h1, h2;
    h1 = k % 32'd11;
    h2 = (k / 32'd11) % 32'd22;
    return {h1, h2};
  endfunction

  // One clock cycle; outputs are observed at the falling edge.
  task automatic tick();
    logic [63:0] e;
    int a;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (!reset_n) begin
      last_res = '0;
      prev_ov  = 1'b0;
    end else begin
      if (out_valid) begin
        check("ready_with_valid", in_ready, 1);
        if (prev_ov) check("valid_pulse_width", 2, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {hash1, hash2}, 64'hx);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("hash1", hash1, e[63:32]);
          check("hash2", hash2, e[31:0]);
          check("latency", cyc - a, LAT);
        end
        last_res = {hash1, hash2};
      end else begin
        check("hold", {hash1, hash2}, last_res);
      end
      prev_ov = out_valid;
    end
  endtask

  task automatic send(input logic [31:0] k);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", in_ready, 1);
    end else begin
      key      = k;
      in_valid = 1'b1;
      exp_q.push_back(model(k));
      acc_q.push_back(cyc + 1);
      tick();
      in_valid = 1'b0;
      key      = $urandom();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    key      = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_hash1", hash1, 0);
    check("rst_hash2", hash2, 0);
    reset_n = 1'b1;
    tick();

    // directed corner keys: 25->3/2, 11->0/1, 253->0/1, all-ones->3/16, 0->0/0
    send(32'd25);
    wait_idle();
    check("key25_h1", hash1, 3);
    check("key25_h2", hash2, 2);
    send(32'd11);
    send(32'd253);
    send(32'hFFFF_FFFF);
    wait_idle();
    check("keyff_h1", hash1, 3);
    check("keyff_h2", hash2, 16);
    send(32'd0);
    wait_idle();

    // busy: key 7 presented during the second division is ignored
    send(32'd25);
    repeat (38) tick();
    key      = 32'd7;
    in_valid = 1'b1;
    repeat (5) begin
      check("busy_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_idle();
    check("busy_h1", hash1, 3);
    check("busy_h2", hash2, 2);

    // back-to-back: key 12 offered in the cycle in_ready returns
    send(32'd25);
    send(32'd12);
    wait_idle();
    check("b2b_h1", hash1, 1);
    check("b2b_h2", hash2, 1);

    // reset mid-computation aborts the key
    send(32'd500);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_hash1", hash1, 0);
    check("abort_hash2", hash2, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_state", state_dbg, IDLE);
    exp_q.delete();
    acc_q.delete();
    tick();
    reset_n = 1'b1;
    repeat (80) tick();

    // random keys, back-to-back, mixing full-range and small values
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) send(32'($urandom_range(0, 600)));
      else send($urandom());
    end
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
